// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and operand helpers for alu_op_sequencer.
// The shift helper is only referenced when ALU_SEQ_SHIFT_EN is defined.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_WRITE_IMM = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_EXEC      = 3'd4,
    ST_WRITE     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic CMD_MOVI = 1'b0;
  localparam logic CMD_ALU  = 1'b1;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  function automatic logic [DATA_W-1:0] sign_ext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v,
                                                input logic [1:0] sh);
    logic [DATA_W-1:0] r;
    case (sh)
      SH_LSL1: r = {v[DATA_W-2:0], 1'b0};
      SH_LSR1: r = {1'b0, v[DATA_W-1:1]};
      SH_ASR1: r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ALU.sv
// Lab datapath ALU: ADD, SUB, AND, NOT B on 16-bit operands, with a zero flag.
module ALU (
  input  logic [15:0] Ain,
  input  logic [15:0] Bin,
  input  logic [1:0]  ALUop,
  output logic [15:0] out,
  output logic        Z
);

  always_comb begin
    out = 16'h0000;
    case (ALUop)
      2'b00:   out = Ain + Bin;
      2'b01:   out = Ain - Bin;
      2'b10:   out = Ain & Bin;
      default: out = ~Bin;
    endcase
  end

  assign Z = (out == 16'h0000);

endmodule

// File: rtl/regfile8x16.sv
// Eight 16-bit registers: one synchronous write port, combinational operand
// and debug read ports, cleared by synchronous reset.
module regfile8x16
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata    = regs[raddr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle MOVI / ALU-op controller around the lab ALU and an 8x16 regfile.
// Define ALU_SEQ_SHIFT_EN to apply the latched shift to the B operand in GET_B.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              cmd,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [ADDR_W-1:0] rd,
  input  logic [7:0]        imm8,
  input  logic [1:0]        shift,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] result,
  output logic              Z_out,
  output logic              N_out,
  output logic              V_out,
  output logic              w
);

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rn_q, rm_q, rd_q;
  logic [7:0]        imm_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              z_q, n_q, v_q;

  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;
  logic              alu_v;

`ifdef ALU_SEQ_SHIFT_EN
  logic [1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset) shift_q <= SH_NONE;
    else if (state == ST_WAIT && s) shift_q <= shift;
  end
`else
  logic unused_shift;
  assign unused_shift = ^shift;
`endif

  // The operand port serves GET_A and GET_B, so the address follows the state.
  assign rf_raddr = (state == ST_GET_A) ? rn_q : rm_q;
  assign rf_we    = (state == ST_WRITE_IMM) || (state == ST_WRITE);
  assign rf_wdata = (state == ST_WRITE_IMM) ? sign_ext8(imm_q) : c_q;

  regfile8x16 u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  ALU u_alu (
    .Ain   (a_q),
    .Bin   (b_q),
    .ALUop (op_q),
    .out   (alu_out),
    .Z     (alu_z)
  );

  // Signed overflow: ADD when same-sign operands give a different-sign result,
  // SUB when differing-sign operands give a result whose sign differs from A.
  always_comb begin
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: alu_v = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                      (alu_out[DATA_W-1] != a_q[DATA_W-1]);
      OP_SUB: alu_v = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                      (alu_out[DATA_W-1] != a_q[DATA_W-1]);
      default: alu_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT;
      op_q  <= OP_ADD;
      rn_q  <= '0;
      rm_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (s) begin
            op_q  <= op;
            rn_q  <= rn;
            rm_q  <= rm;
            rd_q  <= rd;
            imm_q <= imm8;
            state <= (cmd == CMD_MOVI) ? ST_WRITE_IMM : ST_GET_A;
          end
        end
        ST_WRITE_IMM: state <= ST_WAIT;
        ST_GET_A: begin
          a_q   <= rf_rdata;
          state <= ST_GET_B;
        end
        ST_GET_B: begin
`ifdef ALU_SEQ_SHIFT_EN
          b_q <= shift_b(rf_rdata, shift_q);
`else
          b_q <= rf_rdata;
`endif
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          c_q   <= alu_out;
          z_q   <= alu_z;
          n_q   <= alu_out[DATA_W-1];
          v_q   <= alu_v;
          state <= ST_WRITE;
        end
        ST_WRITE: state <= ST_WAIT;
        default:  state <= ST_WAIT;
      endcase
    end
  end

  assign w      = (state == ST_WAIT);
  assign result = c_q;
  assign Z_out  = z_q;
  assign N_out  = n_q;
  assign V_out  = v_q;

endmodule
